// File: rtl/wb_stage.sv
// wb_stage: write-back stage downstream of MEM.
//   Accepts a retiring instruction from MEM, waits for load data from the
//   data cache when needed, aligns/merges load data (LB/LBU/LH/LHU/LW/LWL/LWR)
//   and drives the register-file write port plus forwarding/interlock status.
// Ports:
//   clk, resetn (synchronous, active-low)
//   MEM_* inputs : presented instruction, load type, rt value, cache read data
//   WB_allowin   : WB can accept an instruction this cycle
//   WB_rf_*      : register-file write port
//   WB_pc/inst   : instruction currently in WB (held until the next transfer)
//   WB_load_pending / WB_fwd_valid : interlock and forwarding status
// Optional macro WB_DEBUG_TRACE_EN adds debug_wb_pc, debug_wb_rf_wen,
//   debug_wb_rf_wnum and debug_wb_rf_wdata trace outputs.
//
// state   | meaning
// --------+------------------------------------------
// S_IDLE  | nothing held
// S_WAIT  | load held, cache data outstanding
// S_WRITE | result ready; register-file commit cycle
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              MEM_goto_WB,
   input  logic [31:0]       MEM_pc,
   input  logic [31:0]       MEM_inst,
   input  logic [REG_AW-1:0] MEM_dest,
   input  logic [DATA_W-1:0] MEM_alu_result,
   input  logic              MEM_load,
   input  logic              MEM_LB,
   input  logic              MEM_LBU,
   input  logic              MEM_LH,
   input  logic              MEM_LHU,
   input  logic              MEM_LW,
   input  logic              MEM_LWL,
   input  logic              MEM_LWR,
   input  logic [DATA_W-1:0] MEM_rt_value,
   input  logic [DATA_W-1:0] MEM_mem_rdata,
   input  logic              MEM_mem_rdata_valid,
   output logic              WB_allowin,
   output logic              WB_rf_wen,
   output logic [REG_AW-1:0] WB_rf_waddr,
   output logic [DATA_W-1:0] WB_rf_wdata,
   output logic [31:0]       WB_pc,
   output logic [31:0]       WB_inst,
   output logic              WB_load_pending,
`ifdef WB_DEBUG_TRACE_EN
   output logic              WB_fwd_valid,
   output logic [31:0]       debug_wb_pc,
   output logic [3:0]        debug_wb_rf_wen,
   output logic [4:0]        debug_wb_rf_wnum,
   output logic [31:0]       debug_wb_rf_wdata
`else
   output logic              WB_fwd_valid
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

   localparam logic [2:0] LT_LB  = 3'd0;
   localparam logic [2:0] LT_LBU = 3'd1;
   localparam logic [2:0] LT_LH  = 3'd2;
   localparam logic [2:0] LT_LHU = 3'd3;
   localparam logic [2:0] LT_LW  = 3'd4;
   localparam logic [2:0] LT_LWL = 3'd5;
   localparam logic [2:0] LT_LWR = 3'd6;

   state_t            state_q;
   logic [31:0]       pc_q;
   logic [31:0]       inst_q;
   logic [REG_AW-1:0] dest_q;
   logic [1:0]        addr_q;
   logic [2:0]        ltype_q;
   logic [DATA_W-1:0] rt_q;
   logic [DATA_W-1:0] result_q;

   logic              xfer;
   logic [2:0]        ltype_d;
   logic [DATA_W-1:0] load_data_d;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;

   assign WB_allowin = (state_q != S_WAIT);
   assign xfer       = MEM_goto_WB && WB_allowin;

   // One-hot type flags to a code; a load with no flag set behaves as LW.
   always_comb begin
      ltype_d = LT_LW;
      if      (MEM_LB)  ltype_d = LT_LB;
      else if (MEM_LBU) ltype_d = LT_LBU;
      else if (MEM_LH)  ltype_d = LT_LH;
      else if (MEM_LHU) ltype_d = LT_LHU;
      else if (MEM_LWL) ltype_d = LT_LWL;
      else if (MEM_LWR) ltype_d = LT_LWR;
   end

   always_comb begin
      byte_sel = MEM_mem_rdata[7:0];
      case (addr_q)
         2'd0: byte_sel = MEM_mem_rdata[7:0];
         2'd1: byte_sel = MEM_mem_rdata[15:8];
         2'd2: byte_sel = MEM_mem_rdata[23:16];
         2'd3: byte_sel = MEM_mem_rdata[31:24];
         default: byte_sel = MEM_mem_rdata[7:0];
      endcase
      half_sel = addr_q[1] ? MEM_mem_rdata[31:16] : MEM_mem_rdata[15:0];

      load_data_d = MEM_mem_rdata;
      case (ltype_q)
         LT_LB:  load_data_d = {{24{byte_sel[7]}}, byte_sel};
         LT_LBU: load_data_d = {24'd0, byte_sel};
         LT_LH:  load_data_d = {{16{half_sel[15]}}, half_sel};
         LT_LHU: load_data_d = {16'd0, half_sel};
         LT_LWL: begin
            case (addr_q)
               2'd0: load_data_d = {MEM_mem_rdata[7:0],  rt_q[23:0]};
               2'd1: load_data_d = {MEM_mem_rdata[15:0], rt_q[15:0]};
               2'd2: load_data_d = {MEM_mem_rdata[23:0], rt_q[7:0]};
               default: load_data_d = MEM_mem_rdata;
            endcase
         end
         LT_LWR: begin
            case (addr_q)
               2'd1: load_data_d = {rt_q[31:24], MEM_mem_rdata[31:8]};
               2'd2: load_data_d = {rt_q[31:16], MEM_mem_rdata[31:16]};
               2'd3: load_data_d = {rt_q[31:8],  MEM_mem_rdata[31:24]};
               default: load_data_d = MEM_mem_rdata;
            endcase
         end
         default: load_data_d = MEM_mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         inst_q   <= '0;
         dest_q   <= '0;
         addr_q   <= '0;
         ltype_q  <= LT_LW;
         rt_q     <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            S_WAIT: begin
               if (MEM_mem_rdata_valid) begin
                  result_q <= load_data_d;
                  state_q  <= S_WRITE;
               end
            end
            default: begin
               // IDLE and WRITE both accept a new instruction; WRITE lasts one cycle.
               if (xfer) begin
                  pc_q    <= MEM_pc;
                  inst_q  <= MEM_inst;
                  dest_q  <= MEM_dest;
                  addr_q  <= MEM_alu_result[1:0];
                  ltype_q <= ltype_d;
                  rt_q    <= MEM_rt_value;
                  if (MEM_load) begin
                     state_q <= S_WAIT;
                  end else begin
                     result_q <= MEM_alu_result;
                     state_q  <= S_WRITE;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign WB_rf_wen       = (state_q == S_WRITE) && (dest_q != '0);
   assign WB_rf_waddr     = dest_q;
   assign WB_rf_wdata     = result_q;
   assign WB_fwd_valid    = WB_rf_wen;
   assign WB_pc           = pc_q;
   assign WB_inst         = inst_q;
   assign WB_load_pending = (state_q == S_WAIT) && (dest_q != '0);

`ifdef WB_DEBUG_TRACE_EN
   assign debug_wb_pc       = pc_q;
   assign debug_wb_rf_wen   = {4{WB_rf_wen}};
   assign debug_wb_rf_wnum  = dest_q;
   assign debug_wb_rf_wdata = result_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        resetn;
   logic        MEM_goto_WB;
   logic [31:0] MEM_pc;
   logic [31:0] MEM_inst;
   logic [4:0]  MEM_dest;
   logic [31:0] MEM_alu_result;
   logic        MEM_load;
   logic        MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR;
   logic [31:0] MEM_rt_value;
   logic [31:0] MEM_mem_rdata;
   logic        MEM_mem_rdata_valid;
   logic        WB_allowin, WB_rf_wen, WB_load_pending, WB_fwd_valid;
   logic [4:0]  WB_rf_waddr;
   logic [31:0] WB_rf_wdata, WB_pc, WB_inst;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] F_LB  = 7'b1000000;
   localparam logic [6:0] F_LBU = 7'b0100000;
   localparam logic [6:0] F_LH  = 7'b0010000;
   localparam logic [6:0] F_LHU = 7'b0001000;
   localparam logic [6:0] F_LW  = 7'b0000100;
   localparam logic [6:0] F_LWL = 7'b0000010;
   localparam logic [6:0] F_LWR = 7'b0000001;
   localparam logic [6:0] F_NONE = 7'b0000000;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .resetn(resetn),
      .MEM_goto_WB(MEM_goto_WB), .MEM_pc(MEM_pc), .MEM_inst(MEM_inst),
      .MEM_dest(MEM_dest), .MEM_alu_result(MEM_alu_result), .MEM_load(MEM_load),
      .MEM_LB(MEM_LB), .MEM_LBU(MEM_LBU), .MEM_LH(MEM_LH), .MEM_LHU(MEM_LHU),
      .MEM_LW(MEM_LW), .MEM_LWL(MEM_LWL), .MEM_LWR(MEM_LWR),
      .MEM_rt_value(MEM_rt_value), .MEM_mem_rdata(MEM_mem_rdata),
      .MEM_mem_rdata_valid(MEM_mem_rdata_valid),
      .WB_allowin(WB_allowin), .WB_rf_wen(WB_rf_wen), .WB_rf_waddr(WB_rf_waddr),
      .WB_rf_wdata(WB_rf_wdata), .WB_pc(WB_pc), .WB_inst(WB_inst),
      .WB_load_pending(WB_load_pending), .WB_fwd_valid(WB_fwd_valid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wen"},     {31'd0, WB_rf_wen},       32'd0);
      chk({tag, "_waddr"},   {27'd0, WB_rf_waddr},     32'd0);
      chk({tag, "_wdata"},   WB_rf_wdata,              32'd0);
      chk({tag, "_pc"},      WB_pc,                    32'd0);
      chk({tag, "_inst"},    WB_inst,                  32'd0);
      chk({tag, "_pending"}, {31'd0, WB_load_pending}, 32'd0);
      chk({tag, "_fwd"},     {31'd0, WB_fwd_valid},    32'd0);
      chk({tag, "_allowin"}, {31'd0, WB_allowin},      32'd1);
   endtask

   // Transfer a load, return valid after 'delay' WAIT cycles, check the commit.
   task automatic do_load(input string tag, input logic [6:0] flags, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata, input int delay,
                          input logic [4:0] dest, input logic [31:0] exp);
      MEM_goto_WB = 1'b1;
      MEM_load = 1'b1;
      {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR} = flags;
      MEM_alu_result = addr;
      MEM_rt_value = rt;
      MEM_dest = dest;
      MEM_pc = MEM_pc + 32'd4;
      MEM_inst = 32'h8C000000 | {27'd0, dest};
      step();
      // A second instruction offered during WAIT must not be taken.
      MEM_dest = 5'd30;
      MEM_load = 1'b0;
      MEM_alu_result = 32'hDEADBEEF;
      for (int i = 0; i < delay; i++) begin
         chk({tag, "_allowin_wait"}, {31'd0, WB_allowin}, 32'd0);
         chk({tag, "_pending"}, {31'd0, WB_load_pending}, {31'd0, (dest != 5'd0)});
         chk({tag, "_wen_wait"}, {31'd0, WB_rf_wen}, 32'd0);
         if (i == delay - 1) MEM_mem_rdata_valid = 1'b1;
         MEM_mem_rdata = rdata;
         step();
      end
      MEM_goto_WB = 1'b0;
      MEM_mem_rdata_valid = 1'b0;
      MEM_mem_rdata = 32'h0BADF00D;
      chk({tag, "_wen"}, {31'd0, WB_rf_wen}, {31'd0, (dest != 5'd0)});
      chk({tag, "_fwd"}, {31'd0, WB_fwd_valid}, {31'd0, (dest != 5'd0)});
      chk({tag, "_waddr"}, {27'd0, WB_rf_waddr}, {27'd0, dest});
      if (dest != 5'd0) chk({tag, "_wdata"}, WB_rf_wdata, exp);
      chk({tag, "_pending_done"}, {31'd0, WB_load_pending}, 32'd0);
      step();
      chk({tag, "_idle_wen"}, {31'd0, WB_rf_wen}, 32'd0);
      chk({tag, "_idle_allowin"}, {31'd0, WB_allowin}, 32'd1);
   endtask

   initial begin
      resetn = 1'b0;
      MEM_goto_WB = 1'b0; MEM_pc = 32'h100; MEM_inst = 32'h0; MEM_dest = 5'd0;
      MEM_alu_result = 32'h0; MEM_load = 1'b0;
      {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR} = F_NONE;
      MEM_rt_value = 32'h0; MEM_mem_rdata = 32'h0; MEM_mem_rdata_valid = 1'b0;
      step();
      step();
      chk_reset_outputs("reset");
      resetn = 1'b1;

      // Back-to-back non-loads
      MEM_goto_WB = 1'b1; MEM_dest = 5'd5; MEM_alu_result = 32'h1234;
      MEM_pc = 32'h100; MEM_inst = 32'h00A52820;
      step();
      chk("add1_wen", {31'd0, WB_rf_wen}, 32'd1);
      chk("add1_waddr", {27'd0, WB_rf_waddr}, 32'd5);
      chk("add1_wdata", WB_rf_wdata, 32'h1234);
      chk("add1_fwd", {31'd0, WB_fwd_valid}, 32'd1);
      chk("add1_allowin", {31'd0, WB_allowin}, 32'd1);
      chk("add1_pc", WB_pc, 32'h100);
      chk("add1_inst", WB_inst, 32'h00A52820);
      MEM_dest = 5'd6; MEM_alu_result = 32'h55; MEM_pc = 32'h104; MEM_inst = 32'h00C63020;
      step();
      MEM_goto_WB = 1'b0;
      chk("add2_wen", {31'd0, WB_rf_wen}, 32'd1);
      chk("add2_waddr", {27'd0, WB_rf_waddr}, 32'd6);
      chk("add2_wdata", WB_rf_wdata, 32'h55);
      chk("add2_allowin", {31'd0, WB_allowin}, 32'd1);
      chk("add2_pc", WB_pc, 32'h104);
      step();
      chk("idle_wen", {31'd0, WB_rf_wen}, 32'd0);
      chk("idle_pc_hold", WB_pc, 32'h104);
      chk("idle_inst_hold", WB_inst, 32'h00C63020);

      // Loads
      do_load("lb",   F_LB,   32'h1003, 32'h0, 32'h80FF0000, 3, 5'd8,  32'hFFFFFF80);
      do_load("lbu",  F_LBU,  32'h1003, 32'h0, 32'h80FF0000, 3, 5'd9,  32'h00000080);
      do_load("lb0",  F_LB,   32'h1000, 32'h0, 32'h11223344, 1, 5'd9,  32'h00000044);
      do_load("lh",   F_LH,   32'h1002, 32'h0, 32'h9ABC1234, 1, 5'd10, 32'hFFFF9ABC);
      do_load("lhu",  F_LHU,  32'h1003, 32'h0, 32'h9ABC1234, 2, 5'd11, 32'h00009ABC);
      do_load("lh0",  F_LH,   32'h1000, 32'h0, 32'h9ABC8234, 1, 5'd11, 32'hFFFF8234);
      do_load("lw",   F_LW,   32'h1002, 32'h0, 32'h9ABC1234, 1, 5'd12, 32'h9ABC1234);
      do_load("lwl1", F_LWL,  32'h1001, 32'hAABBCCDD, 32'h11223344, 1, 5'd13, 32'h3344CCDD);
      do_load("lwr2", F_LWR,  32'h1002, 32'hAABBCCDD, 32'h11223344, 1, 5'd14, 32'hAABB1122);
      do_load("lwl3", F_LWL,  32'h1003, 32'hAABBCCDD, 32'h11223344, 1, 5'd15, 32'h11223344);
      do_load("lwr0", F_LWR,  32'h1000, 32'hAABBCCDD, 32'h11223344, 1, 5'd16, 32'h11223344);
      do_load("lwl0", F_LWL,  32'h1000, 32'hAABBCCDD, 32'h11223344, 1, 5'd17, 32'h44BBCCDD);
      do_load("lwr3", F_LWR,  32'h1003, 32'hAABBCCDD, 32'h11223344, 1, 5'd18, 32'hAABBCC11);
      do_load("lnone", F_NONE, 32'h1001, 32'h0, 32'hCAFEF00D, 1, 5'd19, 32'hCAFEF00D);
      do_load("ld0",  F_LW,   32'h1000, 32'h0, 32'h12345678, 2, 5'd0,  32'h0);

      // Stray valid in IDLE
      MEM_mem_rdata_valid = 1'b1; MEM_mem_rdata = 32'h77777777;
      step();
      MEM_mem_rdata_valid = 1'b0;
      chk("stray_wen", {31'd0, WB_rf_wen}, 32'd0);
      chk("stray_allowin", {31'd0, WB_allowin}, 32'd1);
      chk("stray_pending", {31'd0, WB_load_pending}, 32'd0);
      step();
      chk("stray_wen2", {31'd0, WB_rf_wen}, 32'd0);

      // Reset while in WAIT
      MEM_goto_WB = 1'b1; MEM_load = 1'b1;
      {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR} = F_LW;
      MEM_dest = 5'd7; MEM_alu_result = 32'h2000; MEM_pc = 32'h200; MEM_inst = 32'h8C070000;
      step();
      MEM_goto_WB = 1'b0; MEM_load = 1'b0;
      chk("rst_wait_pending", {31'd0, WB_load_pending}, 32'd1);
      chk("rst_wait_allowin", {31'd0, WB_allowin}, 32'd0);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      MEM_mem_rdata_valid = 1'b1; MEM_mem_rdata = 32'h5A5A5A5A;
      step();
      MEM_mem_rdata_valid = 1'b0;
      chk_reset_outputs("rst_wait");
      step();
      chk("rst_wait_wen2", {31'd0, WB_rf_wen}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
